// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared defaults and helpers for the falling-edge register file and its
// busy-bit scoreboard.
//   DEFAULT_WIDTH : data bits per register
//   DEFAULT_DEPTH : number of registers
//   clog2()       : ceiling log2, used to size address ports
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 32;

    // Ceiling log2 for elaboration-time sizing; values <= 1 return 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage : regfile_pkg

// File: rtl/neg_scoreboard.sv
// ----------------------------------------------------------------------------
// neg_scoreboard
// DEPTH busy bits updated on the falling edge of clk. A set and a clear that
// hit the same bit on one edge leave it set (the new reservation wins).
// Ports:
//   clk, rst_n        : clock (falling-edge active), async active-low reset
//   i_set_en/i_set_addr : mark a register busy
//   i_clr_en/i_clr_addr : mark a register free
//   i_lk_a/i_lk_b     : lookup addresses -> o_busy_a/o_busy_b (combinational)
//   o_set_conflict    : i_set_en while the target bit is already busy
// ----------------------------------------------------------------------------
module neg_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_set_en,
    input  logic [AW-1:0] i_set_addr,
    input  logic          i_clr_en,
    input  logic [AW-1:0] i_clr_addr,
    input  logic [AW-1:0] i_lk_a,
    input  logic [AW-1:0] i_lk_b,
    output logic          o_busy_a,
    output logic          o_busy_b,
    output logic          o_set_conflict
);

    logic [DEPTH-1:0] w_busy;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_bit
            logic r_busy;
            logic w_set;
            logic w_clr;

            assign w_set = i_set_en && (i_set_addr == AW'(gi));
            assign w_clr = i_clr_en && (i_clr_addr == AW'(gi));

            // Set is tested first so a same-edge reserve beats the write-back clear.
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_busy <= 1'b0;
                end else if (w_set) begin
                    r_busy <= 1'b1;
                end else if (w_clr) begin
                    r_busy <= 1'b0;
                end
            end

            assign w_busy[gi] = r_busy;
        end
    endgenerate

    assign o_busy_a       = w_busy[i_lk_a];
    assign o_busy_b       = w_busy[i_lk_b];
    assign o_set_conflict = i_set_en & w_busy[i_set_addr];

endmodule : neg_scoreboard

// File: rtl/neg_regfile.sv
// ----------------------------------------------------------------------------
// neg_regfile
// DEPTH x WIDTH register file with byte-enabled writes, two combinational read
// ports and a busy-bit scoreboard. All state changes on the falling edge of
// clk; rst_n clears everything asynchronously.
// Optional feature: define NEG_REGFILE_ZERO_REG_EN to hard-wire register 0
// (reads 0, writes and reservations to address 0 dropped, busy[0] stays 0).
// Ports:
//   clk, rst_n              : clock (falling-edge active), async active-low reset
//   we, waddr, wdata, wbe   : write port with per-byte enables; also frees busy[waddr]
//   raddr_a/b -> rdata_a/b  : combinational reads
//   rsv_en, rsv_addr        : reserve a destination register (sets busy)
//   busy_a/b                : busy[raddr_a] / busy[raddr_b]
//   rsv_conflict            : rsv_en while busy[rsv_addr] is already set
// ----------------------------------------------------------------------------
module neg_regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH/8-1:0] wbe,
    input  logic [AW-1:0]      raddr_a,
    input  logic [AW-1:0]      raddr_b,
    output logic [WIDTH-1:0]   rdata_a,
    output logic [WIDTH-1:0]   rdata_b,
    input  logic               rsv_en,
    input  logic [AW-1:0]      rsv_addr,
    output logic               busy_a,
    output logic               busy_b,
    output logic               rsv_conflict
);

    localparam int NB = WIDTH / 8;

`ifdef NEG_REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    generate
        if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
            $error("neg_regfile: WIDTH (%0d) must be a non-zero multiple of 8", WIDTH);
        end
        if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
            $error("neg_regfile: DEPTH (%0d) must be a power of two >= 2", DEPTH);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Byte-enable expansion: one mask bit per data bit.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_wmask;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_mask
            assign w_wmask[gi*8 +: 8] = {8{wbe[gi]}};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Storage. Each register lives in its own generate scope so every
    // flop group has exactly one driving process; w_words gathers them
    // for the read muxes.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_words [DEPTH];

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (ZERO_REG && gi == 0) begin : g_zero
                assign w_words[gi] = '0;
            end else begin : g_store
                logic [WIDTH-1:0] r_word;
                logic             w_hit;

                assign w_hit = we && (waddr == AW'(gi));

                // Unselected bytes keep their old value; wbe == 0 is a no-op.
                always_ff @(negedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_word <= '0;
                    end else if (w_hit) begin
                        r_word <= (r_word & ~w_wmask) | (wdata & w_wmask);
                    end
                end

                assign w_words[gi] = r_word;
            end
        end
    endgenerate

    assign rdata_a = w_words[raddr_a];
    assign rdata_b = w_words[raddr_b];

    // ------------------------------------------------------------------
    // Scoreboard. With the zero register hard-wired, reservations of
    // address 0 are dropped before they reach the busy bits, so busy[0]
    // can never be set and a conflict on address 0 can never be raised.
    // ------------------------------------------------------------------
    logic w_rsv_set;

    assign w_rsv_set = rsv_en && !(ZERO_REG && rsv_addr == '0);

    neg_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_set_en       (w_rsv_set),
        .i_set_addr     (rsv_addr),
        .i_clr_en       (we),
        .i_clr_addr     (waddr),
        .i_lk_a         (raddr_a),
        .i_lk_b         (raddr_b),
        .o_busy_a       (busy_a),
        .o_busy_b       (busy_b),
        .o_set_conflict (rsv_conflict)
    );

endmodule : neg_regfile

// File: tb/tb_neg_regfile.sv
// ----------------------------------------------------------------------------
// tb_neg_regfile
// Directed bench for neg_regfile (default WIDTH=32, DEPTH=32). Inputs change
// 1 time unit after each falling edge and outputs are checked there, so every
// check sees the state produced by the edge just taken.
// ----------------------------------------------------------------------------
module tb_neg_regfile;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic               clk;
    logic               rst_n;
    logic               we;
    logic [AW-1:0]      waddr;
    logic [WIDTH-1:0]   wdata;
    logic [WIDTH/8-1:0] wbe;
    logic [AW-1:0]      raddr_a;
    logic [AW-1:0]      raddr_b;
    logic [WIDTH-1:0]   rdata_a;
    logic [WIDTH-1:0]   rdata_b;
    logic               rsv_en;
    logic [AW-1:0]      rsv_addr;
    logic               busy_a;
    logic               busy_b;
    logic               rsv_conflict;

    int checks = 0;
    int errors = 0;

    neg_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .wbe          (wbe),
        .raddr_a      (raddr_a),
        .raddr_b      (raddr_b),
        .rdata_a      (rdata_a),
        .rdata_b      (rdata_b),
        .rsv_en       (rsv_en),
        .rsv_addr     (rsv_addr),
        .busy_a       (busy_a),
        .busy_b       (busy_b),
        .rsv_conflict (rsv_conflict)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        we       = 1'b0;
        waddr    = '0;
        wdata    = '0;
        wbe      = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
    endtask

    logic [WIDTH-1:0] exp_r0;
    logic             exp_b0;

    initial begin
        rst_n   = 1'b0;
        raddr_a = '0;
        raddr_b = '0;
        idle();

        // Reset is held across an edge so every flop sees it.
        step();
        chk("rst_conflict", rsv_conflict, 1'b0);
        // Mid-cycle release; takes effect on the following falling edge.
        #2 rst_n = 1'b1;
        step();

        // All addresses read 0 / not busy after reset.
        for (int i = 0; i < DEPTH; i++) begin
            raddr_a = AW'(i);
            raddr_b = AW'(DEPTH - 1 - i);
            #1;
            chk("rst_rdata_a", rdata_a, 32'h0);
            chk("rst_rdata_b", rdata_b, 32'h0);
            chk("rst_busy_a", busy_a, 1'b0);
            chk("rst_busy_b", busy_b, 1'b0);
        end
        $display("txn reset-scan: %0d addresses read back", DEPTH);

        // Full-word write, visible right after the edge that performs it.
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; wbe = 4'b1111;
        raddr_a = 5'd5;
        step();
        chk("wr_full", rdata_a, 32'hDEADBEEF);
        $display("txn write addr=5 data=deadbeef be=1111 rdata=%h", rdata_a);

        // Bytes 0 and 2 only.
        wdata = 32'h11223344; wbe = 4'b0101;
        step();
        chk("wr_partial", rdata_a, 32'hDE22BE44);
        $display("txn write addr=5 data=11223344 be=0101 rdata=%h", rdata_a);

        // wbe all zero: nothing changes.
        wdata = 32'h00000000; wbe = 4'b0000;
        step();
        chk("wr_be0", rdata_a, 32'hDE22BE44);
        // we low: nothing changes.
        we = 1'b0; wdata = 32'h55555555; wbe = 4'b1111;
        step();
        chk("wr_we0", rdata_a, 32'hDE22BE44);
        $display("txn no-op writes addr=5 rdata=%h", rdata_a);
        idle();

        // Reserve 7.
        rsv_en = 1'b1; rsv_addr = 5'd7; raddr_a = 5'd7;
        #1;
        chk("rsv_first_noconflict", rsv_conflict, 1'b0);
        step();
        chk("rsv_busy", busy_a, 1'b1);
        // Second reservation of 7 flags a conflict combinationally.
        chk("rsv_conflict", rsv_conflict, 1'b1);
        step();
        chk("rsv_busy_still", busy_a, 1'b1);
        $display("txn reserve addr=7 busy=%b conflict seen", busy_a);
        // Write-back with no byte enables still frees the register.
        rsv_en = 1'b0; we = 1'b1; waddr = 5'd7; wbe = 4'b0000;
        step();
        chk("wb_clear", busy_a, 1'b0);
        chk("wb_conflict_off", rsv_conflict, 1'b0);
        $display("txn writeback addr=7 busy=%b", busy_a);
        idle();

        // Same-edge reserve and write to 9: reservation wins, data lands.
        rsv_en = 1'b1; rsv_addr = 5'd9;
        we = 1'b1; waddr = 5'd9; wdata = 32'hCAFEF00D; wbe = 4'b1111;
        raddr_a = 5'd9;
        step();
        chk("same_busy9", busy_a, 1'b1);
        chk("same_data9", rdata_a, 32'hCAFEF00D);
        $display("txn rsv+wr addr=9 busy=%b rdata=%h", busy_a, rdata_a);

        // Reserve 4 first so the following write has something to clear.
        rsv_addr = 5'd4; we = 1'b0;
        step();
        // Reserve 3 and write 4 on one edge.
        rsv_addr = 5'd3;
        we = 1'b1; waddr = 5'd4; wdata = 32'h01020304; wbe = 4'b1111;
        raddr_a = 5'd3; raddr_b = 5'd4;
        step();
        chk("diff_busy3", busy_a, 1'b1);
        chk("diff_busy4", busy_b, 1'b0);
        chk("diff_data4", rdata_b, 32'h01020304);
        $display("txn rsv3+wr4 busy3=%b busy4=%b rdata4=%h", busy_a, busy_b, rdata_b);
        idle();

        // Register 0 behaviour depends on the build.
`ifdef NEG_REGFILE_ZERO_REG_EN
        exp_r0 = 32'h00000000;
        exp_b0 = 1'b0;
`else
        exp_r0 = 32'hFFFFFFFF;
        exp_b0 = 1'b1;
`endif
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; wbe = 4'b1111;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        raddr_a = 5'd0;
        step();
        chk("reg0_data", rdata_a, exp_r0);
        chk("reg0_busy", busy_a, exp_b0);
        $display("txn reg0 write+rsv rdata=%h busy=%b", rdata_a, busy_a);
        idle();

        // Populated state before the mid-cycle reset.
        raddr_a = 5'd5; raddr_b = 5'd3;
        #1;
        chk("pre_rst_data5", rdata_a, 32'hDE22BE44);
        chk("pre_rst_busy3", busy_b, 1'b1);

        // Asynchronous reset between edges: outputs clear without a clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("arst_data5", rdata_a, 32'h0);
        chk("arst_busy3", busy_b, 1'b0);
        raddr_a = 5'd9; raddr_b = 5'd4;
        rsv_en = 1'b1; rsv_addr = 5'd9;
        #1;
        chk("arst_data9", rdata_a, 32'h0);
        chk("arst_busy9", busy_a, 1'b0);
        chk("arst_data4", rdata_b, 32'h0);
        chk("arst_conflict", rsv_conflict, 1'b0);
        $display("txn async reset rdata9=%h busy9=%b", rdata_a, busy_a);

        // Writes and reservations ignored while held in reset.
        we = 1'b1; waddr = 5'd9; wdata = 32'h12345678; wbe = 4'b1111;
        step();
        chk("inrst_wr", rdata_a, 32'h0);
        chk("inrst_rsv", busy_a, 1'b0);

        // Release mid-cycle; the pending write/reserve fires on the next edge.
        #2 rst_n = 1'b1;
        #1;
        chk("rel_before_edge", rdata_a, 32'h0);
        step();
        chk("rel_wr", rdata_a, 32'h12345678);
        chk("rel_rsv", busy_a, 1'b1);
        $display("txn post-reset write addr=9 rdata=%h busy=%b", rdata_a, busy_a);
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_neg_regfile

// File: doc/neg_regfile.md
NEG_REGFILE -- requirements
Module: neg_regfile

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving data bits per register.
REQ-002 The block SHALL have parameter DEPTH, default 32, giving the number of registers (power of two, minimum 2).
REQ-003 The block SHALL use derived localparam AW = clog2(DEPTH) for address width; AW is not overridable.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1 bit: the clock; all state updates on its falling edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port we, input, 1 bit: write enable.
REQ-008 Port waddr, input, AW bits: write address.
REQ-009 Port wdata, input, WIDTH bits: write data.
REQ-010 Port wbe, input, WIDTH/8 bits: byte enables for the write.
REQ-011 Port raddr_a / raddr_b, input, AW bits each: read addresses.
REQ-012 Port rdata_a / rdata_b, output, WIDTH bits each: combinational read data.
REQ-013 Port rsv_en, input, 1 bit: reserve a destination register in the scoreboard.
REQ-014 Port rsv_addr, input, AW bits: register to reserve.
REQ-015 Port busy_a / busy_b, output, 1 bit each: scoreboard busy bit of raddr_a / raddr_b.
REQ-016 Port rsv_conflict, output, 1 bit: rsv_en asserted while busy[rsv_addr] is already set.

Function
REQ-017 On negedge clk with we=1, the block SHALL write each byte i of wdata into reg[waddr] where wbe[i]=1 and leave the other bytes unchanged.
REQ-018 With we=0, or wbe all zero, no register SHALL change.
REQ-019 rdata_a/rdata_b SHALL equal reg[raddr_a]/reg[raddr_b] with no latency; a write is visible from the falling edge that performs it.
REQ-020 On negedge clk with rsv_en=1, busy[rsv_addr] SHALL become 1.
REQ-021 On negedge clk with we=1, busy[waddr] SHALL become 0, independent of wbe.
REQ-022 Reserve and write to the same address on the same edge SHALL leave busy=1; the new reservation wins.
REQ-023 Reserve and write to different addresses on the same edge SHALL both take effect.
REQ-024 rsv_conflict SHALL be combinational, equal to rsv_en & busy[rsv_addr]; the reservation still takes effect.
REQ-025 busy_a/busy_b SHALL be combinational lookups of busy[raddr_a]/busy[raddr_b].
REQ-026 WIDTH not a multiple of 8 SHALL be a elaboration error.

Reset
REQ-027 rst_n=0 SHALL immediately clear all registers to 0 and all busy bits to 0, regardless of clk.
REQ-028 While rst_n=0, writes and reservations SHALL be ignored; rdata_* read 0, busy_* and rsv_conflict read 0.
REQ-029 Deassertion mid-cycle SHALL take effect at the next falling edge.

Configuration
REQ-030 Macro NEG_REGFILE_ZERO_REG_EN, when defined, SHALL hard-wire register 0: reads return 0, writes to address 0 are discarded, reservations of address 0 are ignored, busy[0] is always 0.
REQ-031 Without NEG_REGFILE_ZERO_REG_EN, register 0 SHALL behave as any other register.

Structure
REQ-032 Defaults for WIDTH and DEPTH and the clog2 helper SHALL live in the shared package regfile_pkg.
REQ-033 One sub-module, neg_scoreboard (DEPTH busy bits, set/clear/lookup), SHALL hold the scoreboard; storage and byte-merge stay in neg_regfile.

Verification
REQ-034 Reset then read every address -> all rdata 0, all busy 0.
REQ-035 we=1, waddr=5, wdata=0xDEADBEEF, wbe=4'b1111 -> rdata_a=0xDEADBEEF with raddr_a=5 after the falling edge; then wdata=0x11223344, wbe=4'b0101 -> reads 0xDE22BE44.
REQ-036 rsv_en=1, rsv_addr=7 -> busy_a=1 with raddr_a=7; second rsv_en to 7 -> rsv_conflict=1; we to 7 -> busy_a=0.
REQ-037 Same edge rsv_addr=9 and we waddr=9 -> busy[9]=1 and reg[9] updated; same edge rsv_addr=3 and waddr=4 -> busy[3]=1 and busy[4]=0.
REQ-038 With NEG_REGFILE_ZERO_REG_EN: write 0xFFFFFFFF to address 0 and reserve address 0 -> rdata 0, busy 0; without the macro -> rdata 0xFFFFFFFF, busy 1.
REQ-039 Assert rst_n=0 mid-cycle with registers and busy bits populated -> all outputs 0 before the next edge.
